audio_peak_meter: RTL and testbench



---
 rtl/audio_peak_meter_if.sv | 22 ++
 rtl/audio_peak_meter.sv | 148 ++++++++++++++
 tb/tb_audio_peak_meter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/audio_peak_meter_if.sv
// Sample-in / meter-out bundle for audio_peak_meter; master drives PCM samples, slave is the meter.
interface audio_peak_meter_if;
    logic        enable;
    logic [15:0] sample;
    logic        sample_valid;
    logic        clip_clear;
    logic [14:0] peak;
    logic [3:0]  level;
    logic [7:0]  bar;
    logic        level_valid;
    logic        clip;

    modport master (
        output enable, sample, sample_valid, clip_clear,
        input  peak, level, bar, level_valid, clip
    );

    modport slave (
        input  enable, sample, sample_valid, clip_clear,
        output peak, level, bar, level_valid, clip
    );
endinterface

// File: rtl/audio_peak_meter.sv
// Peak-hold/decay meter driving level code and thermometer bar; optional AUDIO_PEAK_CLIP_DETECT_EN.
// Latency: level/bar/level_valid 1 clk after an accepted sample.
// Backpressure: none, every strobed sample is consumed in its cycle.
module audio_peak_meter #(
    parameter int HOLD_CYCLES  = 6000000,
    parameter int DECAY_CYCLES = 1500000,
    parameter int NOISE_FLOOR  = 255
) (
    input logic               i_clk,
    input logic               i_rst_n,
    audio_peak_meter_if.slave bus
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DEC_RELOAD  = DW'(DECAY_CYCLES - 1);
    localparam logic [14:0]   NF          = 15'(NOISE_FLOOR);
    localparam logic [14:0]   STEP        = 15'h1000;

    typedef enum logic [1:0] {IDLE, SILENT, HOLD, DECAY} state_t;

    state_t        state_q, state_d;
    logic [14:0]   peak_q, peak_d;
    logic [14:0]   mag, stepped;
    logic [HW-1:0] hold_q, hold_d;
    logic [DW-1:0] dec_q, dec_d;
    logic [3:0]    level_q, level_d;
    logic [7:0]    bar_q, bar_d;
    logic          level_valid_q;
    logic          accept, capture;

    // -32768 has no 15-bit magnitude, so it saturates to full scale
    always_comb begin
        mag = bus.sample[14:0];
        if (bus.sample == 16'h8000)
            mag = 15'h7FFF;
        else if (bus.sample[15])
            mag = ~bus.sample[14:0] + 15'd1;
    end

    assign accept  = bus.enable && bus.sample_valid && (state_q != IDLE);
    assign capture = accept && ((state_q == SILENT) ? (mag > NF) : (mag >= peak_q));
    assign stepped = (peak_q >= STEP) ? (peak_q - STEP) : 15'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Capture beats hold expiry and decay steps landing in the same clock
    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        hold_d  = hold_q;
        dec_d   = dec_q;
        if (!bus.enable) begin
            state_d = IDLE;
            peak_d  = '0;
            hold_d  = '0;
            dec_d   = '0;
        end else if (capture) begin
            state_d = HOLD;
            peak_d  = mag;
            hold_d  = HOLD_RELOAD;
        end else begin
            case (state_q)
                IDLE:   state_d = SILENT;
                SILENT: state_d = SILENT;
                HOLD: begin
                    if (hold_q == '0) begin
                        state_d = DECAY;
                        dec_d   = DEC_RELOAD;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                DECAY: begin
                    if (dec_q == '0) begin
                        if (stepped <= NF) begin
                            state_d = SILENT;
                            peak_d  = '0;
                            dec_d   = '0;
                        end else begin
                            peak_d = stepped;
                            dec_d  = DEC_RELOAD;
                        end
                    end else begin
                        dec_d = dec_q - DW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        level_d = 4'd0;
        if (peak_d > NF)
            level_d = {1'b0, peak_d[14:12]} + 4'd1;
        bar_d = ~(8'hFF >> level_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            peak_q        <= '0;
            hold_q        <= '0;
            dec_q         <= '0;
            level_q       <= '0;
            bar_q         <= '0;
            level_valid_q <= 1'b0;
        end else begin
            peak_q        <= peak_d;
            hold_q        <= hold_d;
            dec_q         <= dec_d;
            level_q       <= level_d;
            bar_q         <= bar_d;
            level_valid_q <= accept;
        end
    end

    assign bus.peak        = peak_q;
    assign bus.level       = level_q;
    assign bus.bar         = bar_q;
    assign bus.level_valid = level_valid_q;

`ifdef AUDIO_PEAK_CLIP_DETECT_EN
    logic clip_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            clip_q <= 1'b0;
        else if (accept && (bus.sample == 16'h7FFF || bus.sample == 16'h8000))
            clip_q <= 1'b1;
        else if (bus.clip_clear)
            clip_q <= 1'b0;
    end

    assign bus.clip = clip_q;
`else
    logic unused_clip_clear;
    assign unused_clip_clear = bus.clip_clear;
    assign bus.clip = 1'b0;
`endif

endmodule

// File: tb/tb_audio_peak_meter.sv
// Directed bench for audio_peak_meter with short hold/decay periods.
module tb_audio_peak_meter;

`ifdef AUDIO_PEAK_CLIP_DETECT_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    audio_peak_meter_if bus ();

    audio_peak_meter #(
        .HOLD_CYCLES (8),
        .DECAY_CYCLES(4),
        .NOISE_FLOOR (255)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        en;
        logic [15:0] smp;
        logic        vld;
        logic        clr;
        logic [14:0] peak;
        logic [3:0]  lvl;
        logic [7:0]  bar;
        logic        lv;
        logic        clip;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [15:0] smp, input logic vld, input logic clr);
        bus.enable       = en;
        bus.sample       = smp;
        bus.sample_valid = vld;
        bus.clip_clear   = clr;
    endtask

    task automatic check_out(input string name, input int idx, input logic [14:0] peak,
                             input logic [3:0] lvl, input logic [7:0] bar);
        check({name, ".peak"}, idx, 32'(bus.peak), 32'(peak));
        check({name, ".level"}, idx, 32'(bus.level), 32'(lvl));
        check({name, ".bar"}, idx, 32'(bus.bar), 32'(bar));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 15'h0000, 4'd0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h00FF, 1'b1, 1'b0, 15'h0000, 4'd0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 15'h0100, 4'd1, 8'h80, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 16'h8000, 1'b1, 1'b0, 15'h7FFF, 4'd8, 8'hFF, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 15'h0000, 4'd0, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 16'h3000, 1'b1, 1'b0, 15'h0000, 4'd0, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 15'h0000, 4'd0, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 16'hF000, 1'b1, 1'b0, 15'h1000, 4'd2, 8'hC0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 16'h0FFF, 1'b1, 1'b0, 15'h1000, 4'd2, 8'hC0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h7FFF, 1'b1, 1'b0, 15'h7FFF, 4'd8, 8'hFF, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 16'h7FFE, 1'b1, 1'b1, 15'h7FFF, 4'd8, 8'hFF, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 16'h8000, 1'b1, 1'b1, 15'h7FFF, 4'd8, 8'hFF, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 15'h0000, 4'd0, 8'h00, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 16'h0000, 1'b0, 1'b1, 15'h0000, 4'd0, 8'h00, 1'b0, 1'b0};

        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #23;
        check_out("reset", 0, 15'h0, 4'd0, 8'h00);
        check("reset.level_valid", 0, 32'(bus.level_valid), 32'd0);
        check("reset.clip", 0, 32'(bus.clip), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].en, vecs[i].smp, vecs[i].vld, vecs[i].clr);
            step();
            check_out("vec", i, vecs[i].peak, vecs[i].lvl, vecs[i].bar);
            check("vec.level_valid", i, 32'(bus.level_valid), 32'(vecs[i].lv));
            check("vec.clip", i, 32'(bus.clip), 32'(vecs[i].clip & CLIP_EN));
        end

        // Hold for 8 clocks, one decay period, then a 4096 step every 4 clocks
        drive(1'b1, 16'h3000, 1'b1, 1'b0);
        step();
        check_out("decay_cap", 0, 15'h3000, 4'd4, 8'hF0);
        check("decay_cap.level_valid", 0, 32'(bus.level_valid), 32'd1);
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            step();
            if (k < 12)      check_out("decay", k, 15'h3000, 4'd4, 8'hF0);
            else if (k < 16) check_out("decay", k, 15'h2000, 4'd3, 8'hE0);
            else if (k < 20) check_out("decay", k, 15'h1000, 4'd2, 8'hC0);
            else             check_out("decay", k, 15'h0000, 4'd0, 8'h00);
            if (k == 1) check("decay.level_valid", k, 32'(bus.level_valid), 32'd0);
        end
        drive(1'b1, 16'h00FF, 1'b1, 1'b0);
        step();
        check_out("silent_floor", 0, 15'h0, 4'd0, 8'h00);

        // Equal magnitude in DECAY restarts the full hold
        drive(1'b1, 16'h1000, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) step();
        drive(1'b1, 16'h0800, 1'b1, 1'b0);
        step();
        check_out("restart_small", 0, 15'h1000, 4'd2, 8'hC0);
        drive(1'b1, 16'h1000, 1'b1, 1'b0);
        step();
        check_out("restart_eq", 0, 15'h1000, 4'd2, 8'hC0);
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k < 12) check_out("restart_hold", k, 15'h1000, 4'd2, 8'hC0);
            else        check_out("restart_hold", k, 15'h0000, 4'd0, 8'h00);
        end

        // Asynchronous reset mid-DECAY, then the first sample after release is ignored
        drive(1'b1, 16'h8000, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) step();
        check_out("pre_rst", 0, 15'h7FFF, 4'd8, 8'hFF);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 15'h0, 4'd0, 8'h00);
        check("async_rst.clip", 0, 32'(bus.clip), 32'd0);
        drive(1'b1, 16'h3000, 1'b1, 1'b0);
        #2;
        i_rst_n = 1'b1;
        step();
        check_out("post_rst_idle", 0, 15'h0, 4'd0, 8'h00);
        check("post_rst_idle.level_valid", 0, 32'(bus.level_valid), 32'd0);
        step();
        check_out("post_rst_cap", 0, 15'h3000, 4'd4, 8'hF0);
        check("post_rst_cap.level_valid", 0, 32'(bus.level_valid), 32'd1);
        check("post_rst_cap.clip", 0, 32'(bus.clip), 32'd0);

        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
